// File: rtl/control_sequencer.sv
// Microcode sequencer for the 4-bit-address CPU.
// Walks microsteps T0..STEPS-1 and decodes the opcode in IR into a control word.
// Only the step counter and the halted flag are registered; the control word is
// decoded combinationally from the step, the opcode, the flags and halted.
module control_sequencer #(
   parameter int unsigned STEPS     = 5,
   parameter bit          EARLY_END = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] instr,
   input  logic       carry_flag,
   input  logic       zero_flag,
   output logic [2:0] step,
   output logic       halted,
   output logic       pc_out,
   output logic       pc_count,
   output logic       pc_jump,
   output logic       mar_in,
   output logic       ram_in,
   output logic       ram_out,
   output logic       ir_in,
   output logic       ir_out,
   output logic       a_in,
   output logic       a_out,
   output logic       b_in,
   output logic       alu_out,
   output logic       alu_sub,
   output logic       flags_in,
   output logic       out_in
);

   typedef enum logic [2:0] {
      T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
      T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
   } step_t;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
      OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
      OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
   } opcode_t;

   localparam logic [2:0] WRAP_STEP = 3'(STEPS - 1);

   step_t      step_q, step_d;
   logic       halted_q, halted_d;
   step_t      last_exec;
   logic [3:0] opcode;
   logic       unused_operand;

   assign opcode         = instr[7:4];
   assign unused_operand = ^instr[3:0];
   assign step           = step_q;
   assign halted         = halted_q;

   // State register: async active-low reset aborts any instruction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   // Last step that does anything for the current opcode (failed JC/JZ end at T2 too)
   always_comb begin
      last_exec = T2;
      case (opcode)
         OP_LDA, OP_STA: last_exec = T3;
         OP_ADD, OP_SUB: last_exec = T4;
         default:        last_exec = T2;
      endcase
   end

   // Next step / halt: hold when disabled or halted, HLT latches at the end of T2
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (halted_q) begin
         step_d = T0;
      end else if (en) begin
         if (step_q == T2 && opcode == OP_HLT) begin
            halted_d = 1'b1;
            step_d   = T0;
         end else if (step_q == step_t'(WRAP_STEP)) begin
            step_d = T0;
         end else if (EARLY_END && step_q == last_exec) begin
            step_d = T0;
         end else begin
            step_d = step_t'(step_q + 3'd1);
         end
      end
   end

   // Control word decode; everything stays low while halted
   always_comb begin
      pc_out   = 1'b0; pc_count = 1'b0; pc_jump  = 1'b0; mar_in  = 1'b0;
      ram_in   = 1'b0; ram_out  = 1'b0; ir_in    = 1'b0; ir_out  = 1'b0;
      a_in     = 1'b0; a_out    = 1'b0; b_in     = 1'b0; alu_out = 1'b0;
      alu_sub  = 1'b0; flags_in = 1'b0; out_in   = 1'b0;
      if (!halted_q) begin
         case (step_q)
            T0: begin
               pc_out = 1'b1; mar_in = 1'b1;
            end
            T1: begin
               ram_out = 1'b1; ir_in = 1'b1; pc_count = 1'b1;
            end
            T2: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ir_out = 1'b1; mar_in = 1'b1;
                  end
                  OP_LDI: begin
                     ir_out = 1'b1; a_in = 1'b1;
                  end
                  OP_JMP: begin
                     ir_out = 1'b1; pc_jump = 1'b1;
                  end
                  OP_JC: begin
                     ir_out = carry_flag; pc_jump = carry_flag;
                  end
                  OP_JZ: begin
                     ir_out = zero_flag; pc_jump = zero_flag;
                  end
                  OP_OUT: begin
                     a_out = 1'b1; out_in = 1'b1;
                  end
                  default: ;
               endcase
            end
            T3: begin
               case (opcode)
                  OP_LDA: begin
                     ram_out = 1'b1; a_in = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ram_out = 1'b1; b_in = 1'b1;
                  end
                  OP_STA: begin
                     a_out = 1'b1; ram_in = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  alu_out  = 1'b1;
                  a_in     = 1'b1;
                  flags_in = 1'b1;
                  alu_sub  = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class through its
// microsteps and compares step, halted and the full control word at each step.
module tb_control_sequencer;

   // Control word bit masks, order:
   // {pc_out,pc_count,pc_jump,mar_in,ram_in,ram_out,ir_in,ir_out,a_in,a_out,b_in,alu_out,alu_sub,flags_in,out_in}
   localparam logic [14:0] PCO = 15'h4000, PCC = 15'h2000, PCJ = 15'h1000, MAI = 15'h0800;
   localparam logic [14:0] RMI = 15'h0400, RMO = 15'h0200, IRI = 15'h0100, IRO = 15'h0080;
   localparam logic [14:0] AI  = 15'h0040, AO  = 15'h0020, BI  = 15'h0010, ALO = 15'h0008;
   localparam logic [14:0] SUB = 15'h0004, FI  = 15'h0002, OI  = 15'h0001;
   localparam logic [14:0] W_T0 = PCO | MAI;
   localparam logic [14:0] W_T1 = RMO | IRI | PCC;
   localparam logic [14:0] W_Z  = 15'h0000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic [7:0] instr = 8'h1E;
   logic       carry_flag = 1'b0;
   logic       zero_flag = 1'b0;
   logic [2:0] step;
   logic       halted;
   logic       pc_out, pc_count, pc_jump, mar_in, ram_in, ram_out, ir_in, ir_out;
   logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in;
   logic [14:0] cw;

   int checks = 0;
   int errors = 0;

   control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut (
      .clk(clk), .rst(rst), .en(en), .instr(instr),
      .carry_flag(carry_flag), .zero_flag(zero_flag),
      .step(step), .halted(halted),
      .pc_out(pc_out), .pc_count(pc_count), .pc_jump(pc_jump), .mar_in(mar_in),
      .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
      .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
      .alu_sub(alu_sub), .flags_in(flags_in), .out_in(out_in)
   );

   assign cw = {pc_out, pc_count, pc_jump, mar_in, ram_in, ram_out, ir_in, ir_out,
                a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [2:0] exp_step,
                      input logic exp_halted, input logic [14:0] exp_cw);
      checks++;
      assert ({step, halted, cw} === {exp_step, exp_halted, exp_cw})
      else begin
         errors++;
         $error("FAIL %s: observed step=%0d halted=%b cw=%h, expected step=%0d halted=%b cw=%h",
                tag, step, halted, cw, exp_step, exp_halted, exp_cw);
      end
   endtask

   // One clock: inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // Reset held from time 0
      #3;
      chk("reset_word", 3'd0, 1'b0, W_T0);
      @(negedge clk);
      rst = 1'b1;

      // LDA 0x1E
      instr = 8'h1E;
      chk("lda_t0", 3'd0, 1'b0, W_T0);
      tick(); chk("lda_t1", 3'd1, 1'b0, W_T1);
      tick(); chk("lda_t2", 3'd2, 1'b0, IRO | MAI);
      tick(); chk("lda_t3", 3'd3, 1'b0, RMO | AI);
      tick(); chk("lda_early_end", 3'd0, 1'b0, W_T0);

      // ADD aborted by reset mid-T3
      instr = 8'h2A;
      tick(); tick();
      tick(); chk("add_t3", 3'd3, 1'b0, RMO | BI);
      #2 rst = 1'b0;
      #1 chk("async_reset_mid_add", 3'd0, 1'b0, W_T0);
      tick(); chk("reset_held", 3'd0, 1'b0, W_T0);
      rst = 1'b1;

      // JC taken / not taken
      instr = 8'h73; carry_flag = 1'b1;
      tick(); tick(); chk("jc_taken_t2", 3'd2, 1'b0, IRO | PCJ);
      tick(); chk("jc_taken_end", 3'd0, 1'b0, W_T0);
      carry_flag = 1'b0;
      tick(); tick(); chk("jc_not_taken_t2", 3'd2, 1'b0, W_Z);
      tick(); chk("jc_not_taken_end", 3'd0, 1'b0, W_T0);

      // JZ taken / not taken (carry set to show it is ignored)
      instr = 8'h83; zero_flag = 1'b1; carry_flag = 1'b1;
      tick(); tick(); chk("jz_taken_t2", 3'd2, 1'b0, IRO | PCJ);
      tick(); chk("jz_taken_end", 3'd0, 1'b0, W_T0);
      zero_flag = 1'b0;
      tick(); tick(); chk("jz_not_taken_t2", 3'd2, 1'b0, W_Z);
      tick(); chk("jz_not_taken_end", 3'd0, 1'b0, W_T0);
      carry_flag = 1'b0;

      // SUB 0x3F: full five steps
      instr = 8'h3F;
      tick(); chk("sub_t1", 3'd1, 1'b0, W_T1);
      tick(); chk("sub_t2", 3'd2, 1'b0, IRO | MAI);
      tick(); chk("sub_t3", 3'd3, 1'b0, RMO | BI);
      tick(); chk("sub_t4", 3'd4, 1'b0, ALO | SUB | AI | FI);
      tick(); chk("sub_wrap", 3'd0, 1'b0, W_T0);

      // STA 0x4C
      instr = 8'h4C;
      tick(); tick(); chk("sta_t2", 3'd2, 1'b0, IRO | MAI);
      tick(); chk("sta_t3", 3'd3, 1'b0, AO | RMI);
      tick(); chk("sta_end", 3'd0, 1'b0, W_T0);

      // LDI, OUT, undefined opcode
      instr = 8'h55;
      tick(); tick(); chk("ldi_t2", 3'd2, 1'b0, IRO | AI);
      tick(); chk("ldi_end", 3'd0, 1'b0, W_T0);
      instr = 8'hE0;
      tick(); tick(); chk("out_t2", 3'd2, 1'b0, AO | OI);
      tick(); chk("out_end", 3'd0, 1'b0, W_T0);
      instr = 8'hA0;
      tick(); tick(); chk("undef_t2", 3'd2, 1'b0, W_Z);
      tick(); chk("undef_end", 3'd0, 1'b0, W_T0);

      // Enable gating at T1
      instr = 8'h1E;
      tick(); chk("en_t1", 3'd1, 1'b0, W_T1);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("en_hold_t1", 3'd1, 1'b0, W_T1);
      end
      en = 1'b1;
      tick(); chk("en_resume_t2", 3'd2, 1'b0, IRO | MAI);
      tick(); tick(); chk("en_lda_end", 3'd0, 1'b0, W_T0);

      // HLT 0xF0
      instr = 8'hF0;
      tick(); tick(); chk("hlt_t2", 3'd2, 1'b0, W_Z);
      tick(); chk("hlt_latched", 3'd0, 1'b1, W_Z);
      for (int i = 0; i < 10; i++) begin
         en = (i % 2 == 0);
         instr = (i < 5) ? 8'h1E : 8'h73;
         carry_flag = 1'b1;
         tick(); chk("hlt_hold", 3'd0, 1'b1, W_Z);
      end
      en = 1'b1;
      #2 rst = 1'b0;
      #1 chk("hlt_async_clear", 3'd0, 1'b0, W_T0);
      @(negedge clk);
      rst = 1'b1;
      tick(); chk("post_hlt_t1", 3'd1, 1'b0, W_T1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
